// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, FSM states and command format shared by the ALU issue stage.
package alu_pkg;
    localparam int OP_W   = 6;
    localparam int OPND_W = 5;
    localparam logic [OP_W-1:0] OP_ADD  = 6'b000001;
    localparam logic [OP_W-1:0] OP_SUB  = 6'b000010;
    localparam logic [OP_W-1:0] OP_MUL  = 6'b000100;
    localparam logic [OP_W-1:0] OP_ONES = 6'b001000;
    localparam logic [OP_W-1:0] OP_XOR  = 6'b010000;
    localparam logic [OP_W-1:0] OP_MAX  = 6'b100000;
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
    typedef struct packed {
        logic              mod;
        logic [OP_W-1:0]   op;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } cmd_t;
    // IEEE commands ignore op; integer commands need exactly one opcode bit.
    function automatic logic cmd_legal(cmd_t c);
        return c.mod || (c.op != '0 && (c.op & (c.op - OP_W'(1))) == '0);
    endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO with wrap-around pointers and occupancy count.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  cmd_t din,
    output cmd_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    cmd_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic wr, rd;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign dout  = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= rd ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: buffers ALU commands, drops illegal opcodes, drives the ALU
// from registers and holds each sampled result for a valid/ready consumer.
module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RES_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mod,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [OPND_W-1:0] cmd_a,
    input  logic [OPND_W-1:0] cmd_b,
    output logic              alu_mod,
    output logic [OP_W-1:0]   alu_op,
    output logic [OPND_W-1:0] alu_in1,
    output logic [OPND_W-1:0] alu_in2,
    output logic              alu_reset,
    input  logic [RES_W-1:0]  alu_out,
    input  logic              alu_balance,
    input  logic              alu_equality,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              res_balance,
    output logic              res_equality,
    output logic              err_illegal
);
    state_t state, state_n;
    cmd_t cmd_in, head;
    logic full, empty, push, pop, load, cap, legal;
    assign cmd_ready = !full && !reset;
    assign push      = cmd_valid && cmd_ready;
    assign cmd_in    = {cmd_mod, cmd_op, cmd_a, cmd_b};
    assign legal     = cmd_legal(head);
    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (cmd_in),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        load    = 1'b0;
        cap     = 1'b0;
        case (state)
            IDLE: begin
                pop     = !empty;
                load    = !empty && legal;
                state_n = load ? EXEC : IDLE;
            end
            EXEC: begin
                cap     = 1'b1;
                state_n = HOLD;
            end
            HOLD: begin
                pop     = res_ready && !empty;
                load    = res_ready && !empty && legal;
                state_n = load ? EXEC : (res_ready ? IDLE : HOLD);
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        alu_reset <= reset;
        if (reset) begin
            state        <= IDLE;
            alu_mod      <= 1'b0;
            alu_op       <= '0;
            alu_in1      <= '0;
            alu_in2      <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_balance  <= 1'b0;
            res_equality <= 1'b0;
            err_illegal  <= 1'b0;
        end else begin
            state       <= state_n;
            err_illegal <= pop && !legal;
            res_valid   <= cap || (res_valid && !res_ready);
            if (load) begin
                alu_mod <= head.mod;
                alu_op  <= head.op;
                alu_in1 <= head.a;
                alu_in2 <= head.b;
            end
            // ALU inputs have been stable for the whole EXEC cycle when sampled here.
            if (cap) begin
                res_data     <= alu_out;
                res_balance  <= alu_balance;
                res_equality <= alu_equality;
            end
        end
    end
endmodule
